hwpe_stream_tcdm_load_issuer: RTL and testbench
===============================================

HWPE_STREAM_TCDM_LOAD_ISSUER -- requirements
Module: hwpe_stream_tcdm_load_issuer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of TCDM read data and of data_o.data.
REQ-002 SHALL have parameter DEPTH, default 4: max responses outstanding plus buffered; power of two, >=2.
REQ-003 SHALL have port clk_i, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enable_i, input, 1: permits issuing new TCDM requests.
REQ-006 SHALL have port clear_i, input, 1: synchronous flush (REQ-021).
REQ-007 SHALL have port addr_i, hwpe_stream_intf_stream.sink, 32: byte addresses consumed from an address-generator stream.
REQ-008 SHALL have port tcdm, hwpe_stream_intf_tcdm.initiator, 32 add / DATA_WIDTH data: req, gnt, add, wen, be, data out; r_data, r_valid in.
REQ-009 SHALL have port data_o, hwpe_stream_intf_stream.source, DATA_WIDTH: loaded data, in address order.
REQ-010 SHALL have port idle_o, output, 1: no request in flight, buffer empty, nothing to discard.
REQ-011 SHALL have port err_o, output, 1: sticky unexpected-response flag.

Function
REQ-012 SHALL drive tcdm.req = addr_i.valid & enable_i & ~clear_i & credit_ok & (discard_cnt==0), purely combinationally.
REQ-013 SHALL drive tcdm.add = addr_i.data, tcdm.wen = 1 (read), tcdm.be = all ones, tcdm.data = 0.
REQ-014 SHALL drive addr_i.ready = tcdm.req & tcdm.gnt; an address is consumed only on grant; req held with stable add until granted.
REQ-015 SHALL keep inflight_cnt ($clog2(DEPTH+1) bits): +1 on req&gnt, -1 on accepted r_valid, net 0 when both in one cycle.
REQ-016 SHALL buffer responses in a DEPTH-entry FIFO: push r_data on r_valid when discard_cnt==0; pop on data_o.valid & data_o.ready; simultaneous push/pop keeps occupancy.
REQ-017 SHALL set credit_ok = (inflight_cnt + fifo_cnt) < DEPTH, using registered values; never more than DEPTH entries committed.
REQ-018 SHALL drive data_o.valid = FIFO not empty, data_o.data = FIFO head, data_o.strb = all ones; data_o.valid never depends on data_o.ready.
REQ-019 SHALL accept tcdm.r_valid every cycle regardless of enable_i or data_o.ready (TCDM responses not stallable).
REQ-020 SHALL set err_o on r_valid when inflight_cnt==0 and discard_cnt==0; response dropped; err_o cleared only by rst_i or clear_i.
REQ-021 SHALL on clear_i: empty FIFO, inflight_cnt<=0, discard_cnt<=inflight_cnt + (r_valid?-1:0)... precisely: discard_cnt <= inflight_cnt - (r_valid & discard_cnt==0 ? 1 : 0) + discard_cnt - (r_valid & discard_cnt>0 ? 1 : 0); err_o<=0.
REQ-022 SHALL drop each r_valid while discard_cnt>0 and decrement discard_cnt; no new requests until discard_cnt==0.
REQ-023 SHALL drive idle_o = (inflight_cnt==0) & (fifo_cnt==0) & (discard_cnt==0).
REQ-024 SHALL return data in grant order; TCDM responses arrive in order, latency >=1 cycle after grant.
REQ-025 SHALL allow one grant per cycle back-to-back when credit_ok holds (full throughput with DEPTH>=2 and data_o.ready=1).

Reset
REQ-026 SHALL on rst_i: inflight_cnt, fifo_cnt, discard_cnt, FIFO pointers, err_o <= 0; hence tcdm.req=0, data_o.valid=0, addr_i.ready=0, idle_o=1 in the cycle after reset.
REQ-027 SHALL give rst_i priority over clear_i, clear_i priority over all other updates.

Verification
REQ-028 SHALL cover streaming: 8 addresses 0x100..0x11C, gnt=1, r_valid 1 cycle later, data_o.ready=1 -> 8 beats in order, one per cycle, idle_o=1 after last pop.
REQ-029 SHALL cover backpressure: DEPTH=4, data_o.ready=0, 10 addresses -> exactly 4 grants, then req=0; after ready=1, remaining 6 issued, 10 beats in order, none lost.
REQ-030 SHALL cover grant stall: gnt=0 for 5 cycles with addr_i.valid=1 -> req=1 and add stable throughout, addr_i.ready=0 until gnt.
REQ-031 SHALL cover clear with 3 in flight: clear_i pulse -> FIFO empty, next 3 r_valid dropped, req held low until then, idle_o=1 afterward, no data_o beat.
REQ-032 SHALL cover spurious response: r_valid with idle_o=1 -> err_o=1 next cycle and sticky, data_o.valid stays 0; clear_i -> err_o=0.
REQ-033 SHALL cover enable_i=0 mid-stream with 2 in flight -> no new req, both responses still buffered and delivered.

Source files
------------

// File: rtl/hwpe_stream_tcdm_load_issuer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : hwpe_stream_intf_stream / hwpe_stream_intf_tcdm
// Description : Valid/ready stream bundle and TCDM initiator/target bundle.
// Revision    : 1.0 - initial release
// ============================================================================

interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      valid;
    logic                      ready;
    logic [DATA_WIDTH-1:0]     data;
    logic [DATA_WIDTH/8-1:0]   strb;

    modport source (output valid, data, strb, input ready);
    modport sink   (input valid, data, strb, output ready);
endinterface

interface hwpe_stream_intf_tcdm #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      req;
    logic                      gnt;
    logic [31:0]               add;
    logic                      wen;
    logic [DATA_WIDTH/8-1:0]   be;
    logic [DATA_WIDTH-1:0]     data;
    logic [DATA_WIDTH-1:0]     r_data;
    logic                      r_valid;

    modport initiator (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport target    (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

`default_nettype wire

// File: rtl/hwpe_stream_tcdm_load_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : hwpe_stream_tcdm_load_issuer
// Description : Turns an address stream into TCDM reads and returns the data
//               in order through a credit-limited response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================

module hwpe_stream_tcdm_load_issuer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    hwpe_stream_intf_stream.sink     addr_i,
    hwpe_stream_intf_tcdm.initiator  tcdm,
    hwpe_stream_intf_stream.source   data_o,
    output logic                     idle_o,
    output logic                     err_o
);

    localparam int unsigned c_cnt_w = $clog2(DEPTH + 1);
    localparam int unsigned c_ptr_w = $clog2(DEPTH);

    logic [c_cnt_w-1:0]    inflight_q, inflight_d;
    logic [c_cnt_w-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [c_cnt_w-1:0]    discard_q,  discard_d;
    logic [c_ptr_w-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [c_ptr_w-1:0]    rd_ptr_q,   rd_ptr_d;
    logic                  err_q,      err_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [c_cnt_w:0]      w_committed;
    logic [c_cnt_w:0]      w_pending;
    logic [c_cnt_w:0]      w_flush_cnt;
    logic                  w_credit_ok;
    logic                  w_no_discard;
    logic                  w_req;
    logic                  w_grant;
    logic                  w_accept;
    logic                  w_spurious;
    logic                  w_drop;
    logic                  w_pop;

    // Credits count both outstanding reads and buffered data, so the FIFO can never overflow.
    assign w_committed  = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    assign w_credit_ok  = w_committed < (c_cnt_w + 1)'(DEPTH);
    assign w_no_discard = (discard_q == '0);

    assign w_req      = addr_i.valid & enable_i & ~clear_i & w_credit_ok & w_no_discard;
    assign w_grant    = w_req & tcdm.gnt;
    assign w_accept   = tcdm.r_valid & w_no_discard & (inflight_q != '0);
    assign w_spurious = tcdm.r_valid & w_no_discard & (inflight_q == '0);
    assign w_drop     = tcdm.r_valid & ~w_no_discard;
    assign w_pop      = data_o.valid & data_o.ready;

    // On flush, every read still owed by memory must be swallowed; a response arriving now is one of them.
    assign w_pending   = {1'b0, inflight_q} + {1'b0, discard_q};
    assign w_flush_cnt = w_pending - {{c_cnt_w{1'b0}}, (tcdm.r_valid && (w_pending != '0))};

    assign tcdm.req   = w_req;
    assign tcdm.add   = addr_i.data;
    assign tcdm.wen   = 1'b1;
    assign tcdm.be    = '1;
    assign tcdm.data  = '0;
    assign addr_i.ready = w_grant;

    assign data_o.valid = (fifo_cnt_q != '0);
    assign data_o.data  = mem_q[rd_ptr_q];
    assign data_o.strb  = '1;

    assign idle_o = (inflight_q == '0) & (fifo_cnt_q == '0) & w_no_discard;
    assign err_o  = err_q;

    always_comb begin
        inflight_d = inflight_q;
        fifo_cnt_d = fifo_cnt_q;
        discard_d  = discard_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        err_d      = err_q;

        if (clear_i) begin
            inflight_d = '0;
            fifo_cnt_d = '0;
            discard_d  = c_cnt_w'(w_flush_cnt);
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            err_d      = 1'b0;
        end else begin
            inflight_d = inflight_q + c_cnt_w'(w_grant) - c_cnt_w'(w_accept);
            fifo_cnt_d = fifo_cnt_q + c_cnt_w'(w_accept) - c_cnt_w'(w_pop);
            if (w_accept) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (w_drop) begin
                discard_d = discard_q - 1'b1;
            end
            if (w_spurious) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            discard_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            discard_q  <= discard_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            mem_q[wr_ptr_q] <= tcdm.r_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hwpe_stream_tcdm_load_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hwpe_stream_tcdm_load_issuer
// Description : Scoreboard bench with a behavioural TCDM target for the issuer.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_hwpe_stream_tcdm_load_issuer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, enable, clear, idle, err;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) addr_s ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) data_s ();
    hwpe_stream_intf_tcdm   #(.DATA_WIDTH(DW)) tcdm_s ();

    hwpe_stream_tcdm_load_issuer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (enable),
        .clear_i  (clear),
        .addr_i   (addr_s.sink),
        .tcdm     (tcdm_s.initiator),
        .data_o   (data_s.source),
        .idle_o   (idle),
        .err_o    (err)
    );

    typedef struct {
        logic [31:0] d;
        int          due;
    } resp_t;

    typedef struct {
        logic [31:0] base;
        int          n;
        int          lat;
        int          gmode;
        int          rmode;
        int          exp_beats;
        logic        exp_idle;
    } vec_t;

    vec_t        tbl [4];
    logic [31:0] addr_q [$];
    logic [31:0] exp_q  [$];
    resp_t       rq     [$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int lat = 1;
    int gmode = 0;   // 0 always grant, 1 random, 2 never
    int rmode = 0;   // 0 always ready, 1 random, 2 never
    bit spur = 1'b0;
    int beats = 0;
    int n_gr = 0;
    int first_cyc = -1;
    int last_cyc = -1;

    logic        s_req, s_ardy, s_idle, s_err, s_dv;
    logic [31:0] s_add;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    task automatic drive();
        addr_s.valid = (addr_q.size() > 0);
        addr_s.data  = (addr_q.size() > 0) ? addr_q[0] : 32'h0;
        addr_s.strb  = '1;
        case (gmode)
            0:       tcdm_s.gnt = 1'b1;
            1:       tcdm_s.gnt = 1'($urandom_range(0, 1));
            default: tcdm_s.gnt = 1'b0;
        endcase
        case (rmode)
            0:       data_s.ready = 1'b1;
            1:       data_s.ready = 1'($urandom_range(0, 1));
            default: data_s.ready = 1'b0;
        endcase
        if (spur) begin
            tcdm_s.r_valid = 1'b1;
            tcdm_s.r_data  = 32'hDEAD_BEEF;
        end else if (rq.size() > 0 && rq[0].due <= cyc) begin
            tcdm_s.r_valid = 1'b1;
            tcdm_s.r_data  = rq[0].d;
        end else begin
            tcdm_s.r_valid = 1'b0;
            tcdm_s.r_data  = 32'h0;
        end
    endtask

    // One cycle: drive at the falling edge, sample 1 ns later, apply handshake effects after the rising edge.
    task automatic tick();
        logic        acc, gr, ov, rvm;
        logic [31:0] aval, gadd, od;
        resp_t       r;
        drive();
        #1;
        acc  = addr_s.valid && addr_s.ready;
        aval = addr_s.data;
        gr   = tcdm_s.req && tcdm_s.gnt;
        gadd = tcdm_s.add;
        ov   = data_s.valid && data_s.ready;
        od   = data_s.data;
        rvm  = tcdm_s.r_valid && !spur;
        s_req = tcdm_s.req; s_add = gadd; s_ardy = addr_s.ready;
        s_idle = idle; s_err = err; s_dv = data_s.valid;
        if (ov) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat: got 0x%0h expected no beat", od);
            end else begin
                chk("beat_data", od, exp_q.pop_front());
            end
            beats++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        if (acc) begin
            void'(addr_q.pop_front());
            exp_q.push_back(mem_f(aval));
        end
        if (gr) begin
            r.d   = mem_f(gadd);
            r.due = cyc + lat - 1;
            rq.push_back(r);
            n_gr++;
        end
        if (rvm) void'(rq.pop_front());
        if (clear) exp_q.delete();
        @(negedge clk);
    endtask

    task automatic run_done(input string name, input int budget);
        int k;
        bit busy;
        k = 0;
        do begin
            tick();
            k++;
            busy = (addr_q.size() != 0) || (exp_q.size() != 0) || (rq.size() != 0) || (s_idle !== 1'b1);
        end while (busy && k < budget);
        chk({name, "_completes"}, 32'(!busy), 32'd1);
    endtask

    task automatic push_addrs(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) addr_q.push_back(base + 32'(4 * i));
    endtask

    initial begin
        int bad_req;
        int k;

        tbl[0] = '{base: 32'h200, n: 6,  lat: 2, gmode: 1, rmode: 0, exp_beats: 6,  exp_idle: 1'b1};
        tbl[1] = '{base: 32'h300, n: 10, lat: 3, gmode: 0, rmode: 1, exp_beats: 10, exp_idle: 1'b1};
        tbl[2] = '{base: 32'h400, n: 5,  lat: 1, gmode: 1, rmode: 1, exp_beats: 5,  exp_idle: 1'b1};
        tbl[3] = '{base: 32'h500, n: 12, lat: 4, gmode: 0, rmode: 0, exp_beats: 12, exp_idle: 1'b1};

        rst = 1'b1; enable = 1'b1; clear = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_idle", 32'(s_idle), 32'd1);
        chk("reset_req", 32'(s_req), 32'd0);
        chk("reset_dvalid", 32'(s_dv), 32'd0);
        chk("reset_aready", 32'(s_ardy), 32'd0);
        chk("reset_err", 32'(s_err), 32'd0);

        // Streaming: one beat per cycle, in order.
        lat = 1; gmode = 0; rmode = 0;
        beats = 0; first_cyc = -1;
        push_addrs(32'h100, 8);
        run_done("stream", 200);
        chk("stream_beats", 32'(beats), 32'd8);
        chk("stream_back_to_back", 32'(last_cyc - first_cyc), 32'd7);
        chk("stream_idle", 32'(s_idle), 32'd1);

        for (int i = 0; i < 4; i++) begin
            lat = tbl[i].lat; gmode = tbl[i].gmode; rmode = tbl[i].rmode;
            beats = 0;
            push_addrs(tbl[i].base, tbl[i].n);
            run_done($sformatf("vec%0d", i), 400);
            chk($sformatf("vec%0d_beats", i), 32'(beats), 32'(tbl[i].exp_beats));
            chk($sformatf("vec%0d_idle", i), 32'(s_idle), 32'(tbl[i].exp_idle));
        end
        chk("no_err_after_vectors", 32'(s_err), 32'd0);

        // Backpressure: only DEPTH reads may be committed.
        lat = 1; gmode = 0; rmode = 2;
        beats = 0; n_gr = 0;
        push_addrs(32'h600, 10);
        repeat (20) tick();
        chk("bp_grants", 32'(n_gr), 32'd4);
        chk("bp_req_low", 32'(s_req), 32'd0);
        chk("bp_dvalid", 32'(s_dv), 32'd1);
        rmode = 0;
        run_done("bp", 200);
        chk("bp_beats", 32'(beats), 32'd10);
        chk("bp_total_grants", 32'(n_gr), 32'd10);

        // Grant stall: request and address must hold.
        gmode = 2; beats = 0;
        push_addrs(32'h700, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_req", 32'(s_req), 32'd1);
            chk("stall_add", s_add, 32'h700);
            chk("stall_aready", 32'(s_ardy), 32'd0);
        end
        gmode = 0;
        run_done("stall", 100);
        chk("stall_beats", 32'(beats), 32'd1);

        // Clear with three reads in flight.
        lat = 6; gmode = 0; rmode = 0;
        beats = 0; n_gr = 0;
        push_addrs(32'h800, 3);
        repeat (3) tick();
        chk("clr_inflight_grants", 32'(n_gr), 32'd3);
        push_addrs(32'h900, 2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        bad_req = 0; k = 0;
        while (rq.size() > 0 && k < 50) begin
            tick();
            if (s_req !== 1'b0) bad_req++;
            k++;
        end
        chk("clr_drained", 32'(rq.size()), 32'd0);
        chk("clr_req_held_low", 32'(bad_req), 32'd0);
        chk("clr_no_beats", 32'(beats), 32'd0);
        tick();
        chk("clr_idle_after", 32'(s_idle), 32'd1);
        chk("clr_req_resumes", 32'(s_req), 32'd1);
        run_done("clr", 200);
        chk("clr_new_beats", 32'(beats), 32'd2);

        // Spurious response while idle.
        lat = 1; beats = 0;
        spur = 1'b1;
        tick();
        spur = 1'b0;
        tick();
        chk("spur_err_set", 32'(s_err), 32'd1);
        chk("spur_no_dvalid", 32'(s_dv), 32'd0);
        repeat (3) tick();
        chk("spur_err_sticky", 32'(s_err), 32'd1);
        chk("spur_idle", 32'(s_idle), 32'd1);
        chk("spur_no_beats", 32'(beats), 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        chk("spur_err_cleared", 32'(s_err), 32'd0);

        // Disable mid-stream with two reads in flight.
        lat = 4; gmode = 0; rmode = 0;
        beats = 0; n_gr = 0;
        push_addrs(32'hA00, 4);
        repeat (2) tick();
        enable = 1'b0;
        repeat (10) tick();
        chk("en_grants_frozen", 32'(n_gr), 32'd2);
        chk("en_beats_delivered", 32'(beats), 32'd2);
        chk("en_req_low", 32'(s_req), 32'd0);
        enable = 1'b1;
        run_done("en", 200);
        chk("en_total_beats", 32'(beats), 32'd4);
        chk("en_total_grants", 32'(n_gr), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
